phase_cmd_parser: RTL

PHASE_CMD_PARSER -- requirements
Module: phase_cmd_parser

---
 rtl/phase_cmd_parser.sv | 119 +++++++++++
 1 files changed

// File: rtl/phase_cmd_parser.sv
// phase_cmd_parser: decodes host byte packets from the RX FIFO into phase register writes and commit strobes.
//   clk, rst_n       : clock, asynchronous active-low reset
//   enable           : allows a new packet to start (ignored mid-packet)
//   rxfifo_empty     : RX FIFO empty flag
//   rxfifo_rdreq     : RX FIFO pop, data returned one cycle later on rxfifo_data
//   rxfifo_data      : RX FIFO read data
//   sync_tick        : transducer period boundary strobe
//   phase_we/_addr/_wdata : shadow phase register write port
//   commit           : shadow phases become active
//   busy             : parser is inside a packet
//   err_count        : malformed packet count, saturating at 255
module phase_cmd_parser #(
    parameter int NUM_CHANNELS = 4,
    parameter int ADDR_W       = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              rxfifo_empty,
    output logic              rxfifo_rdreq,
    input  logic [7:0]        rxfifo_data,
    input  logic              sync_tick,
    output logic              phase_we,
    output logic [ADDR_W-1:0] phase_addr,
    output logic [7:0]        phase_wdata,
    output logic              commit,
    output logic              busy,
    output logic [7:0]        err_count
);

    typedef enum logic [2:0] {
        IDLE, CMD_CAP, ADDR_RD, ADDR_CAP, PHASE_RD, PHASE_CAP, COMMIT_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic                run_q;
    logic [7:0]          addr_q, addr_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [7:0]          wdata_q, wdata_d;
    logic                commit_q, commit_d;
    logic [7:0]          err_q, err_d;
    logic                err_inc;
    logic                addr_ok;

    // run_q holds off the first pop until one clock edge has passed with reset released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            run_q    <= 1'b0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            paddr_q  <= '0;
            wdata_q  <= '0;
            commit_q <= 1'b0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            run_q    <= 1'b1;
            addr_q   <= addr_d;
            we_q     <= we_d;
            paddr_q  <= paddr_d;
            wdata_q  <= wdata_d;
            commit_q <= commit_d;
            err_q    <= err_d;
        end
    end

    assign addr_ok = ({24'd0, addr_q} < NUM_CHANNELS);

    always_comb begin
        // The pop must see this cycle's empty flag to never underflow the FIFO, so it is not registered.
        rxfifo_rdreq = run_q && !rxfifo_empty &&
                       ((state_q == IDLE && enable) || state_q == ADDR_RD || state_q == PHASE_RD);
        state_d  = state_q;
        addr_d   = addr_q;
        we_d     = 1'b0;
        paddr_d  = paddr_q;
        wdata_d  = wdata_q;
        commit_d = 1'b0;
        err_inc  = 1'b0;
        case (state_q)
            IDLE:     state_d = rxfifo_rdreq ? CMD_CAP : IDLE;
            CMD_CAP: begin
                state_d = (rxfifo_data == 8'h01) ? ADDR_RD :
                          (rxfifo_data == 8'h02) ? COMMIT_WAIT : IDLE;
                err_inc = (rxfifo_data != 8'h01) && (rxfifo_data != 8'h02);
            end
            ADDR_RD:  state_d = rxfifo_rdreq ? ADDR_CAP : ADDR_RD;
            ADDR_CAP: begin
                addr_d  = rxfifo_data;
                state_d = PHASE_RD;
            end
            PHASE_RD: state_d = rxfifo_rdreq ? PHASE_CAP : PHASE_RD;
            PHASE_CAP: begin
                // The phase byte has already been consumed; an out-of-range address only counts as an error.
                we_d    = addr_ok;
                paddr_d = addr_ok ? addr_q[ADDR_W-1:0] : paddr_q;
                wdata_d = addr_ok ? rxfifo_data : wdata_q;
                err_inc = !addr_ok;
                state_d = IDLE;
            end
            COMMIT_WAIT: begin
                commit_d = sync_tick;
                state_d  = sync_tick ? IDLE : COMMIT_WAIT;
            end
            default:  state_d = IDLE;
        endcase
        err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end

    assign busy        = (state_q != IDLE);
    assign phase_we    = we_q;
    assign phase_addr  = paddr_q;
    assign phase_wdata = wdata_q;
    assign commit      = commit_q;
    assign err_count   = err_q;

endmodule
